// File: rtl/psum_collector_pkg.sv
// ----------------------------------------------------------------------------
// psum_collector_pkg
//
// Purpose:
//   Shared constants and types for the systolic-array partial-sum collector.
//   Default geometry matches a 4-column array with 16-bit signed psums and
//   a 4-row output FIFO.
//
// Contents:
//   N_DEF       default number of array columns
//   PSUM_W_DEF  default signed partial-sum width per column
//   DEPTH_DEF   default FIFO depth in rows
//   CNT_W       width of the accepted-row counter
//   psum_t      signed partial-sum type at the default width
//   av_kind_e   classification of the deskewed (aligned) valid vector
// ----------------------------------------------------------------------------
package psum_collector_pkg;

    localparam int N_DEF      = 4;
    localparam int PSUM_W_DEF = 16;
    localparam int DEPTH_DEF  = 4;
    localparam int CNT_W      = 16;

    typedef logic signed [PSUM_W_DEF-1:0] psum_t;

    // Every cycle the aligned valid vector is exactly one of these.
    typedef enum logic [1:0] {
        AV_IDLE     = 2'd0,
        AV_ROW      = 2'd1,
        AV_MISALIGN = 2'd2
    } av_kind_e;

endpackage

// File: rtl/row_fifo.sv
// ----------------------------------------------------------------------------
// row_fifo
//
// Purpose:
//   Small synchronous FIFO holding fully aligned result rows. The head entry
//   is presented combinationally on rdata_o, so it stays stable until popped.
//   A push while full is honoured only if a pop happens in the same cycle.
//   All storage clears on reset so the head reads as zero afterwards.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   push_i   in   write wdata_i at the tail
//   wdata_i  in   W-bit row to write
//   pop_i    in   remove the head entry (ignored when empty)
//   rdata_o  out  head entry
//   level_o  out  occupancy, 0..DEPTH
//   full_o   out  level_o == DEPTH
//   empty_o  out  level_o == 0
// ----------------------------------------------------------------------------
module row_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [LW-1:0] level_q, level_d;
    logic          doPush;
    logic          doPop;

    assign full_o  = (level_q == DEPTH_L);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rdPtr_q];

    // A full FIFO can still take a row when the head leaves in the same cycle.
    assign doPop  = pop_i & ~empty_o;
    assign doPush = push_i & (~full_o | doPop);

    // Pointer and occupancy update; DEPTH is a power of two so the
    // pointers wrap on their own.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + AW'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + AW'(1);
        end
        case ({doPush, doPop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            level_q <= level_d;
        end
    end

    // Storage is cleared on reset so no stale row is visible at the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/psum_collector.sv
// ----------------------------------------------------------------------------
// psum_collector
//
// Purpose:
//   Sits under the bottom PE row of the systolic MAC array. Column j delivers
//   its partial sum j cycles after column 0 for the same output row; this
//   block deskews the columns, assembles one aligned row, buffers rows in a
//   small FIFO and hands them to the downstream writer over valid/ready.
//   A misaligned valid pattern sets sticky ERR; a row arriving while the
//   FIFO is full (and not draining) is dropped and sets sticky OVF.
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   asynchronous active-high reset
//   COL_VALID  in   per-column down-enable, bit j = column j
//   COL_PSUM   in   per-column signed psum, column j at [j*PSUM_W +: PSUM_W]
//   OUT_VALID  out  a row is available at OUT_ROW
//   OUT_READY  in   downstream takes the row this cycle
//   OUT_ROW    out  head row, same packing as COL_PSUM
//   ROW_CNT    out  rows accepted into the FIFO, wraps at 2^16
//   OVF        out  sticky, a row was dropped because the FIFO was full
//   ERR        out  sticky, deskewed valids were neither all-ones nor idle
//   LEVEL      out  FIFO occupancy
//
// Configuration:
//   COLLECT_RELU_EN  when defined, negative column values are written to the
//                    FIFO as zero; otherwise values are stored bit-exact.
// ----------------------------------------------------------------------------
module psum_collector
    import psum_collector_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int PSUM_W = PSUM_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N-1:0]             COL_VALID,
    input  logic [N*PSUM_W-1:0]      COL_PSUM,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [N*PSUM_W-1:0]      OUT_ROW,
    output logic [CNT_W-1:0]         ROW_CNT,
    output logic                     OVF,
    output logic                     ERR,
    output logic [$clog2(DEPTH):0]   LEVEL
);

    logic [N-1:0]        avVld;
    logic [N*PSUM_W-1:0] wrRow;
    av_kind_e            avKind;
    logic                fifoFull;
    logic                fifoEmpty;
    logic                popFire;
    logic                pushFire;
    logic                ovfSet;
    logic [CNT_W-1:0]    rowCnt_q, rowCnt_d;
    logic                ovf_q, ovf_d;
    logic                err_q, err_d;

    // Deskew: column j goes through N-1-j always-shifting stages so every
    // column of one row lines up with the last column, which is unregistered.
    for (genvar j = 0; j < N; j++) begin : g_col
        localparam int D = N - 1 - j;
        logic              dskVld;
        logic [PSUM_W-1:0] dskData;

        if (D == 0) begin : g_pass
            assign dskVld  = COL_VALID[j];
            assign dskData = COL_PSUM[j*PSUM_W +: PSUM_W];
        end else begin : g_dly
            logic [D-1:0]      vld_q;
            logic [PSUM_W-1:0] dat_q [D];

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    vld_q <= '0;
                    for (int k = 0; k < D; k++) begin
                        dat_q[k] <= '0;
                    end
                end else begin
                    vld_q[0] <= COL_VALID[j];
                    dat_q[0] <= COL_PSUM[j*PSUM_W +: PSUM_W];
                    for (int k = 1; k < D; k++) begin
                        vld_q[k] <= vld_q[k-1];
                        dat_q[k] <= dat_q[k-1];
                    end
                end
            end

            assign dskVld  = vld_q[D-1];
            assign dskData = dat_q[D-1];
        end

        assign avVld[j] = dskVld;

`ifdef COLLECT_RELU_EN
        assign wrRow[j*PSUM_W +: PSUM_W] = dskData[PSUM_W-1] ? '0 : dskData;
`else
        assign wrRow[j*PSUM_W +: PSUM_W] = dskData;
`endif
    end

    // Classify the aligned valid vector: full row, idle, or misaligned.
    always_comb begin
        avKind = AV_IDLE;
        if (avVld == '1) begin
            avKind = AV_ROW;
        end else if (avVld != '0) begin
            avKind = AV_MISALIGN;
        end
    end

    assign OUT_VALID = ~fifoEmpty;
    assign popFire   = OUT_VALID & OUT_READY;
    assign pushFire  = (avKind == AV_ROW) & (~fifoFull | popFire);
    assign ovfSet    = (avKind == AV_ROW) & fifoFull & ~popFire;

    // Counter and sticky flags; the flags only ever clear on reset.
    always_comb begin
        rowCnt_d = rowCnt_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        if (pushFire) begin
            rowCnt_d = rowCnt_q + CNT_W'(1);
        end
        if (ovfSet) begin
            ovf_d = 1'b1;
        end
        if (avKind == AV_MISALIGN) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rowCnt_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rowCnt_q <= rowCnt_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign ROW_CNT = rowCnt_q;
    assign OVF     = ovf_q;
    assign ERR     = err_q;

    row_fifo #(
        .W     (N*PSUM_W),
        .DEPTH (DEPTH)
    ) u_row_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push_i  (pushFire),
        .wdata_i (wrRow),
        .pop_i   (popFire),
        .rdata_o (OUT_ROW),
        .level_o (LEVEL),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

endmodule

// File: tb/tb_psum_collector.sv
// ----------------------------------------------------------------------------
// tb_psum_collector
//
// Purpose:
//   Directed self-checking bench for psum_collector at N=4, PSUM_W=16,
//   DEPTH=4. Each scenario fills a per-cycle stimulus schedule, plays it,
//   records the outputs of every cycle, and compares against hand-computed
//   values. Inputs change 1 time unit after the rising edge; outputs are
//   sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_psum_collector;
    import psum_collector_pkg::*;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int RW    = N * W;
    localparam int SLOTS = 32;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [N-1:0]  COL_VALID = '0;
    logic [RW-1:0] COL_PSUM = '0;
    logic          OUT_VALID;
    logic          OUT_READY = 1'b0;
    logic [RW-1:0] OUT_ROW;
    logic [15:0]   ROW_CNT;
    logic          OVF;
    logic          ERR;
    logic [2:0]    LEVEL;

    int checks = 0;
    int errors = 0;

    logic [N-1:0]  vSch     [SLOTS];
    logic [RW-1:0] dSch     [SLOTS];
    logic          rdySch   [SLOTS];
    logic          obsValid [SLOTS];
    logic [RW-1:0] obsRow   [SLOTS];
    logic [2:0]    obsLevel [SLOTS];
    logic [15:0]   obsCnt   [SLOTS];
    logic          obsOvf   [SLOTS];
    logic          obsErr   [SLOTS];

    always #5 CLK = ~CLK;

    psum_collector #(
        .N      (N),
        .PSUM_W (W),
        .DEPTH  (DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .COL_VALID (COL_VALID),
        .COL_PSUM  (COL_PSUM),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_ROW   (OUT_ROW),
        .ROW_CNT   (ROW_CNT),
        .OVF       (OVF),
        .ERR       (ERR),
        .LEVEL     (LEVEL)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Row r of the counting pattern: column j holds 16*r + j + 1.
    function automatic logic [RW-1:0] mkRow(input int r);
        logic [RW-1:0] row;
        row = '0;
        for (int j = 0; j < N; j++) begin
            row[j*W +: W] = 16'(16 * r + j + 1);
        end
        return row;
    endfunction

    task automatic clearSched();
        for (int c = 0; c < SLOTS; c++) begin
            vSch[c]   = '0;
            dSch[c]   = '0;
            rdySch[c] = 1'b0;
        end
    endtask

    // Schedule one skewed row starting at cycle t0; lateCol (if >=0) arrives
    // one cycle later than it should.
    task automatic addRow(input int t0, input logic [RW-1:0] row, input int lateCol);
        for (int j = 0; j < N; j++) begin
            int c;
            c = t0 + j + ((j == lateCol) ? 1 : 0);
            vSch[c][j]        = 1'b1;
            dSch[c][j*W +: W] = row[j*W +: W];
        end
    endtask

    task automatic setReady(input int first, input int last);
        for (int c = first; c <= last; c++) begin
            rdySch[c] = 1'b1;
        end
    endtask

    task automatic doReset();
        @(posedge CLK);
        #1;
        RST       = 1'b1;
        COL_VALID = '0;
        COL_PSUM  = '0;
        OUT_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // Play the schedule for len cycles; optionally pulse RST during rstCycle.
    task automatic applyStimulus(input int len, input int rstCycle);
        for (int c = 0; c < len; c++) begin
            @(posedge CLK);
            #1;
            COL_VALID = vSch[c];
            COL_PSUM  = dSch[c];
            OUT_READY = rdySch[c];
            if (c == rstCycle) begin
                RST = 1'b1;
            end else if (c == rstCycle + 1) begin
                RST = 1'b0;
            end
            @(negedge CLK);
            obsValid[c] = OUT_VALID;
            obsRow[c]   = OUT_ROW;
            obsLevel[c] = LEVEL;
            obsCnt[c]   = ROW_CNT;
            obsOvf[c]   = OVF;
            obsErr[c]   = ERR;
        end
        COL_VALID = '0;
        COL_PSUM  = '0;
        OUT_READY = 1'b0;
    endtask

    initial begin
        logic [RW-1:0] rowOne;
        logic [RW-1:0] expOne;
        logic          anyValid;

        // ---------------- reset state ----------------
        doReset();
        @(negedge CLK);
        checkOutput("rst_valid", 64'(OUT_VALID), 64'(0));
        checkOutput("rst_row",   64'(OUT_ROW),   64'(0));
        checkOutput("rst_level", 64'(LEVEL),     64'(0));
        checkOutput("rst_cnt",   64'(ROW_CNT),   64'(0));
        checkOutput("rst_ovf",   64'(OVF),       64'(0));
        checkOutput("rst_err",   64'(ERR),       64'(0));

        // ---------------- 1: single row, signed values ----------------
        clearSched();
        rowOne = {psum_t'(-32768), psum_t'(100), psum_t'(-3), psum_t'(5)};
`ifdef COLLECT_RELU_EN
        expOne = 64'h0000_0064_0000_0005;
`else
        expOne = 64'h8000_0064_FFFD_0005;
`endif
        addRow(2, rowOne, -1);
        applyStimulus(10, -1);
        checkOutput("t1_valid_early", 64'(obsValid[5]), 64'(0));
        checkOutput("t1_valid",       64'(obsValid[6]), 64'(1));
        checkOutput("t1_row",         64'(obsRow[6]),   expOne);
        checkOutput("t1_cnt",         64'(obsCnt[6]),   64'(1));
        checkOutput("t1_level",       64'(obsLevel[6]), 64'(1));
        checkOutput("t1_row_hold",    64'(obsRow[9]),   expOne);

        // ---------------- 2: back-to-back rows, always ready ----------------
        doReset();
        clearSched();
        for (int r = 0; r < 4; r++) begin
            addRow(2 + r, mkRow(r), -1);
        end
        setReady(0, 15);
        applyStimulus(14, -1);
        for (int r = 0; r < 4; r++) begin
            checkOutput($sformatf("t2_valid%0d", r), 64'(obsValid[6+r]), 64'(1));
            checkOutput($sformatf("t2_row%0d", r),   64'(obsRow[6+r]),   64'(mkRow(r)));
            checkOutput($sformatf("t2_level%0d", r), 64'(obsLevel[6+r]), 64'(1));
        end
        checkOutput("t2_drained", 64'(obsLevel[10]), 64'(0));
        checkOutput("t2_cnt",     64'(obsCnt[10]),   64'(4));
        checkOutput("t2_ovf",     64'(obsOvf[13]),   64'(0));

        // ---------------- 3: overflow, then drain ----------------
        doReset();
        clearSched();
        for (int r = 0; r < 5; r++) begin
            addRow(2 + r, mkRow(r), -1);
        end
        setReady(12, 20);
        applyStimulus(20, -1);
        checkOutput("t3_level_full", 64'(obsLevel[9]), 64'(4));
        checkOutput("t3_ovf_before", 64'(obsOvf[9]),   64'(0));
        checkOutput("t3_ovf",        64'(obsOvf[10]),  64'(1));
        checkOutput("t3_cnt",        64'(obsCnt[10]),  64'(4));
        checkOutput("t3_level_hold", 64'(obsLevel[11]), 64'(4));
        for (int r = 0; r < 4; r++) begin
            checkOutput($sformatf("t3_drain%0d", r), 64'(obsRow[12+r]), 64'(mkRow(r)));
        end
        checkOutput("t3_empty", 64'(obsValid[16]), 64'(0));

        // ---------------- 4: full, push and pop together ----------------
        doReset();
        clearSched();
        for (int r = 0; r < 4; r++) begin
            addRow(2 + r, mkRow(r), -1);
        end
        addRow(10, mkRow(4), -1);
        rdySch[13] = 1'b1;
        setReady(16, 22);
        applyStimulus(22, -1);
        checkOutput("t4_full",      64'(obsLevel[12]), 64'(4));
        checkOutput("t4_head_pop",  64'(obsRow[13]),   64'(mkRow(0)));
        checkOutput("t4_level",     64'(obsLevel[14]), 64'(4));
        checkOutput("t4_ovf",       64'(obsOvf[14]),   64'(0));
        checkOutput("t4_cnt",       64'(obsCnt[14]),   64'(5));
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t4_drain%0d", i), 64'(obsRow[16+i]), 64'(mkRow(i + 1)));
        end
        checkOutput("t4_empty", 64'(obsLevel[20]), 64'(0));

        // ---------------- 5: misaligned column 2 ----------------
        doReset();
        clearSched();
        addRow(2, mkRow(0), 2);
        addRow(8, mkRow(1), -1);
        applyStimulus(16, -1);
        checkOutput("t5_err_before", 64'(obsErr[5]),   64'(0));
        checkOutput("t5_err",        64'(obsErr[6]),   64'(1));
        checkOutput("t5_no_row",     64'(obsValid[10]), 64'(0));
        checkOutput("t5_cnt_zero",   64'(obsCnt[10]),  64'(0));
        checkOutput("t5_later_valid", 64'(obsValid[12]), 64'(1));
        checkOutput("t5_later_row",  64'(obsRow[12]),  64'(mkRow(1)));
        checkOutput("t5_later_cnt",  64'(obsCnt[12]),  64'(1));
        checkOutput("t5_err_sticky", 64'(obsErr[15]),  64'(1));

        // ---------------- 6: reset mid-operation ----------------
        doReset();
        clearSched();
        for (int r = 0; r < 3; r++) begin
            addRow(2 + r, mkRow(r), -1);
        end
        vSch[7][0]           = 1'b1;
        dSch[7][0*W +: W]    = 16'h0031;
        vSch[8][1]           = 1'b1;
        dSch[8][1*W +: W]    = 16'h0032;
        applyStimulus(18, 9);
        checkOutput("t6_level_pre", 64'(obsLevel[8]), 64'(3));
        checkOutput("t6_valid_rst", 64'(obsValid[9]), 64'(0));
        checkOutput("t6_row_rst",   64'(obsRow[9]),   64'(0));
        checkOutput("t6_level_rst", 64'(obsLevel[9]), 64'(0));
        checkOutput("t6_cnt_rst",   64'(obsCnt[9]),   64'(0));
        anyValid = 1'b0;
        for (int c = 10; c < 18; c++) begin
            anyValid = anyValid | obsValid[c];
        end
        checkOutput("t6_no_row_after", 64'(anyValid),    64'(0));
        checkOutput("t6_err_after",    64'(obsErr[17]),  64'(0));
        checkOutput("t6_cnt_after",    64'(obsCnt[17]),  64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
